uart_led_cmd_rx: RTL and testbench

Fabric-side UART receiver (8N1) that listens to the MSS MMUART_1 transmit line.
It decodes a small byte-command protocol that drives the four board LEDs, so firmware can control the LEDs over the UART instead of the free-running blinker.
It runs on the fabric CCC clock, sits beside the LED logic in the top level, and also exposes every received byte for other fabric consumers.

---
 rtl/uart_led_cmd_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_led_cmd_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_led_cmd_rx.sv
// 8N1 UART receiver with a small byte-command decoder that drives four LEDs.
// Every correctly framed byte is also presented on RX_DATA/RX_VALID.
module uart_led_cmd_rx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] CMD_SET      = 8'h4C,
  parameter logic [7:0] CMD_CLR      = 8'h43,
  parameter logic [7:0] CMD_TGL      = 8'h54
) (
  input  logic       FAB_CLK,
  input  logic       FAB_RESET,
  input  logic       UART_RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       CMD_ERR,
  output logic [3:0] LED
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Counter restarts on the IDLE->START edge, so mid-start lands at HALF-1.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [0:0] {
    CMD_IDLE = 1'b0,
    CMD_ARG  = 1'b1
  } cmd_state_t;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic          r_cmd_err;
  logic [3:0]    r_led;
  rx_state_t     r_rx_state;
  cmd_state_t    r_cmd_state;

  logic          w_rxd_s;
  rx_state_t     w_rx_next;
  logic          w_cnt_clr;
  logic          w_shift_en;
  logic          w_bit_clr;
  logic          w_valid_set;
  logic          w_ferr_set;
  cmd_state_t    w_cmd_next;
  logic [3:0]    w_led_next;
  logic          w_cmd_err_set;

  assign w_rxd_s   = r_sync[1];
  assign RX_DATA   = r_rx_data;
  assign RX_VALID  = r_rx_valid;
  assign FRAME_ERR = r_frame_err;
  assign CMD_ERR   = r_cmd_err;
  assign LED       = r_led;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], UART_RXD};
    end
  end

  // Bit-period counter, wraps every CLKS_PER_BIT cycles.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_cnt <= '0;
    end else if (w_cnt_clr || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // RX state register.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_rx_state <= ST_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  // RX next-state and control strobes.
  always_comb begin
    w_rx_next   = r_rx_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_bit_clr   = 1'b0;
    w_valid_set = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rxd_s) begin
          w_rx_next = ST_START;
        end else begin
          w_rx_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr = 1'b1;
          w_bit_clr = 1'b1;
          if (w_rxd_s) begin
            w_rx_next = ST_IDLE;
          end else begin
            w_rx_next = ST_DATA;
          end
        end else begin
          w_rx_next = ST_START;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
            w_rx_next = ST_STOP;
          end else begin
            w_rx_next = ST_DATA;
          end
        end else begin
          w_rx_next = ST_DATA;
        end
      end
      ST_STOP: begin
        if (r_cnt == CNT_LAST) begin
          if (w_rxd_s) begin
            w_valid_set = 1'b1;
            w_rx_next   = ST_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_rx_next   = ST_BREAK;
          end
        end else begin
          w_rx_next = ST_STOP;
        end
      end
      ST_BREAK: begin
        w_cnt_clr = 1'b1;
        if (w_rxd_s) begin
          w_rx_next = ST_IDLE;
        end else begin
          w_rx_next = ST_BREAK;
        end
      end
      default: begin
        w_cnt_clr = 1'b1;
        w_rx_next = ST_IDLE;
      end
    endcase
  end

  // Data path: LSB-first shift register, bit index and registered RX outputs.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_shift     <= 8'h00;
      r_bit       <= 3'd0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift <= {w_rxd_s, r_shift[7:1]};
      end
      if (w_bit_clr) begin
        r_bit <= 3'd0;
      end else if (w_shift_en) begin
        r_bit <= r_bit + 3'd1;
      end
      if (w_valid_set) begin
        r_rx_data <= r_shift;
      end
      r_rx_valid  <= w_valid_set;
      r_frame_err <= w_ferr_set;
    end
  end

  // Command state, LED register and command-error pulse.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_cmd_state <= CMD_IDLE;
      r_led       <= 4'h0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_state <= w_cmd_next;
      r_led       <= w_led_next;
      r_cmd_err   <= w_cmd_err_set;
    end
  end

  // Command decode acts on the registered RX_VALID/FRAME_ERR cycle.
  always_comb begin
    w_cmd_next    = r_cmd_state;
    w_led_next    = r_led;
    w_cmd_err_set = 1'b0;
    case (r_cmd_state)
      CMD_IDLE: begin
        if (r_rx_valid) begin
          if (r_rx_data == CMD_SET) begin
            w_cmd_next = CMD_ARG;
          end else if (r_rx_data == CMD_CLR) begin
            w_led_next = 4'h0;
          end else if (r_rx_data == CMD_TGL) begin
            w_led_next = ~r_led;
          end else begin
            w_cmd_err_set = 1'b1;
          end
        end else begin
          w_cmd_next = CMD_IDLE;
        end
      end
      CMD_ARG: begin
        if (r_rx_valid) begin
          w_led_next = r_rx_data[3:0];
          w_cmd_next = CMD_IDLE;
        end else if (r_frame_err) begin
          w_cmd_next = CMD_IDLE;
        end else begin
          w_cmd_next = CMD_ARG;
        end
      end
      default: begin
        w_cmd_next = CMD_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_led_cmd_rx.sv
// Directed bench for uart_led_cmd_rx at 8 clocks per bit.
module tb_uart_led_cmd_rx;

  localparam int CPB = 8;

  logic       fab_clk;
  logic       fab_reset;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_err;
  logic [3:0] led;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0, ferr_cnt = 0, cerr_cnt = 0;
  int valid_cyc = 0, cerr_cyc = 0, fall_cyc = 0;
  int pulse_viol = 0;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_c = 1'b0;
  int saved_valid, saved_ferr;

  uart_led_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .FAB_CLK   (fab_clk),
    .FAB_RESET (fab_reset),
    .UART_RXD  (uart_rxd),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .FRAME_ERR (frame_err),
    .CMD_ERR   (cmd_err),
    .LED       (led)
  );

  initial fab_clk = 1'b0;
  always #5 fab_clk = ~fab_clk;

  always @(posedge fab_clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  always @(negedge fab_clk) begin
    if (rx_valid === 1'b1) begin valid_cnt++; valid_cyc = cyc; end
    if (frame_err === 1'b1) ferr_cnt++;
    if (cmd_err === 1'b1) begin cerr_cnt++; cerr_cyc = cyc; end
    if ((rx_valid && prev_v) || (frame_err && prev_f) || (cmd_err && prev_c) || (rx_valid && frame_err))
      pulse_viol++;
    prev_v = rx_valid;
    prev_f = frame_err;
    prev_c = cmd_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    uart_rxd = b;
    repeat (n) @(posedge fab_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge fab_clk); #1;
    fall_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop, CPB);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
    drive(1'b1, 2 * CPB);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge fab_clk);
    check({tag, "_data"}, rx_data, 8'h00);
    check({tag, "_valid"}, rx_valid, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_cerr"}, cmd_err, 1'b0);
    check({tag, "_led"}, led, 4'h0);
  endtask

  initial begin
    fab_reset = 1'b1;
    uart_rxd  = 1'b1;
    repeat (3) @(posedge fab_clk);
    check_outputs_zero("rst_in");
    @(posedge fab_clk); #1;
    fab_reset = 1'b0;
    drive(1'b1, 4);
    check_outputs_zero("rst_out");

    // Frame timing: 0xA5, pulse 79 cycles after the pin falls.
    send_frame(8'hA5, 1'b1);
    check("a5_cnt", valid_cnt, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_latency", valid_cyc - fall_cyc, 79);
    check("a5_no_ferr", ferr_cnt, 0);
    drive(1'b1, 2 * CPB);

    // Glitch: 3 low cycles must not start a frame.
    uart_rxd = 1'b0;
    drive(1'b0, 3);
    drive(1'b1, 3 * CPB);
    check("glitch_valid", valid_cnt, 1);
    check("glitch_ferr", ferr_cnt, 0);
    send_byte(8'h3C);
    check("3c_cnt", valid_cnt, 2);
    check("3c_data", rx_data, 8'h3C);

    // Framing error with a long break.
    send_frame(8'h55, 1'b0);
    drive(1'b0, 40 * CPB);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_valid", valid_cnt, 2);
    check("ferr_keep_data", rx_data, 8'h3C);
    drive(1'b1, 2 * CPB);
    send_byte(8'h0F);
    check("0f_data", rx_data, 8'h0F);
    check("0f_cnt", valid_cnt, 3);
    check("0f_ferr", ferr_cnt, 1);
    check("unk_cerr", cerr_cnt, 3);
    check("unk_led", led, 4'h0);

    // Commands.
    send_byte(8'h4C); send_byte(8'h09);
    check("set_9", led, 4'b1001);
    send_byte(8'h54);
    check("tgl_6", led, 4'b0110);
    send_byte(8'h43);
    check("clr_0", led, 4'b0000);
    send_byte(8'h7A);
    check("7a_cerr", cerr_cnt, 4);
    check("7a_led", led, 4'h0);
    check("7a_cerr_timing", cerr_cyc - valid_cyc, 1);
    send_byte(8'h4C); send_byte(8'h54);
    check("set_t_led", led, 4'h4);
    check("set_t_cerr", cerr_cnt, 4);

    // Argument abort by framing error.
    send_byte(8'h4C); send_byte(8'h03);
    check("set_3", led, 4'h3);
    send_byte(8'h4C);
    send_frame(8'h00, 1'b0);
    drive(1'b1, 2 * CPB);
    check("abort_ferr", ferr_cnt, 2);
    check("abort_led", led, 4'h3);
    send_byte(8'h54);
    check("abort_tgl", led, 4'hC);

    // Reset during data bit 4.
    saved_valid = valid_cnt;
    saved_ferr  = ferr_cnt;
    @(posedge fab_clk); #1;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b0, 3);
    fab_reset = 1'b1;
    uart_rxd  = 1'b1;
    repeat (3) @(posedge fab_clk);
    check_outputs_zero("midrst");
    @(posedge fab_clk); #1;
    fab_reset = 1'b0;
    drive(1'b1, 12 * CPB);
    check("midrst_valid", valid_cnt, saved_valid);
    check("midrst_ferr", ferr_cnt, saved_ferr);
    check("midrst_led", led, 4'h0);
    send_byte(8'h81);
    check("81_data", rx_data, 8'h81);
    check("81_cnt", valid_cnt, saved_valid + 1);
    check("81_led", led, 4'h0);

    check("pulse_rules", pulse_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
